// File: rtl/r22sdf_pkg.sv
// ---------------------------------------------------------------------------
// r22sdf_pkg
// Shared definitions for the radix-2^2 SDF FFT frame sequencer.
//   - state_t : controller state encoding (INIT=0, IDLE=1, RUN=2, FLUSH=3)
//   - clog2   : ceiling log2, matches the helper used by logfunc.vh users
//   - clog4   : ceiling log4, number of radix-2^2 butterfly stages
//   - DEF_FFT_LENGTH / DEF_IDX_W : default transform size and bin-index width
// ---------------------------------------------------------------------------
package r22sdf_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int clog4(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 15; i++) begin
            if ((1 << (2 * i)) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_FFT_LENGTH = 16;
    localparam int DEF_IDX_W      = clog2(DEF_FFT_LENGTH);

endpackage

// File: rtl/r22sdf_bitrev.sv
// ---------------------------------------------------------------------------
// r22sdf_bitrev
// Purely combinational bit reverser of parameterised width. Maps the
// digit-reversed arrival order of the R2^2 pipeline onto true frequency bins.
// Ports:
//   din  [width-1:0]  value to reverse
//   dout [width-1:0]  din with bit order reversed (dout[i] = din[width-1-i])
// ---------------------------------------------------------------------------
module r22sdf_bitrev #(
    parameter int width = 4
) (
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    for (genvar i = 0; i < width; i++) begin : g_rev
        assign dout[i] = din[width-1-i];
    end

endmodule

// File: rtl/r22sdf_ctrl.sv
// ---------------------------------------------------------------------------
// r22sdf_ctrl
// Frame sequencer for the radix-2^2 SDF FFT pipeline. Gates the global
// pipeline enable from the input stream, waits for every twiddle stage to
// report ready, tracks pipeline fill, drains the last frame with zero
// samples and tags the output stream with valid/sop/eop/bin index.
//
// Parameters:
//   fft_length    transform size (power of 4, >= 4)
//   num_stages    number of butterfly stages (width of cordic_rdy)
//   pipe_latency  enabled cycles from input sample 0 to output sample 0
//
// Ports:
//   sys_clk, sys_nrst   clock, synchronous active-low reset
//   din_valid/din_sop   input sample present / sample is frame index 0
//   flush_req           drain the pipeline after the current frame
//   cordic_rdy          per-stage twiddle table ready
//   din_ready           sample accepted this cycle
//   din_zero            upstream must feed zero samples (flush)
//   sys_en_glb          pipeline advance enable
//   dout_valid/sop/eop  registered output tags, aligned with stage data
//   dout_idx            output bin index
//   busy                controller in RUN or FLUSH
//   err_sop             one-cycle pulse on a misplaced din_sop
//
// Build option:
//   R22SDF_BITREV_IDX_EN  when defined, dout_idx is the bit-reversed output
//                         counter (true frequency bin); otherwise dout_idx is
//                         the arrival-order counter.
// ---------------------------------------------------------------------------
module r22sdf_ctrl
    import r22sdf_pkg::*;
#(
    parameter int fft_length   = 16,
    parameter int num_stages   = clog4(fft_length),
    parameter int pipe_latency = fft_length - 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_nrst,
    input  logic                         din_valid,
    input  logic                         din_sop,
    input  logic                         flush_req,
    input  logic [num_stages-1:0]        cordic_rdy,
    output logic                         din_ready,
    output logic                         din_zero,
    output logic                         sys_en_glb,
    output logic                         dout_valid,
    output logic                         dout_sop,
    output logic                         dout_eop,
    output logic [clog2(fft_length)-1:0] dout_idx,
    output logic                         busy,
    output logic                         err_sop
);

    localparam int IDX_W = clog2(fft_length);
    localparam int CNT_W = clog2(pipe_latency + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(fft_length - 1);
    localparam logic [CNT_W-1:0] FILL_FULL  = CNT_W'(pipe_latency);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(pipe_latency - 1);

    state_t           state;
    logic [IDX_W-1:0] in_cnt;
    logic [IDX_W-1:0] out_cnt;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             flush_latch;
    logic             flush_stop;

    logic             rdy_ok;
    logic             filled;
    logic             emit;
    logic             lose_rdy;
    logic [IDX_W-1:0] idx_next;

    assign rdy_ok   = &cordic_rdy;
    assign filled   = (fill_cnt == FILL_FULL);
    assign busy     = (state == RUN) || (state == FLUSH);
    assign lose_rdy = busy && !rdy_ok;

    // Outputs stop once the last real frame has left during a flush; the
    // remaining zero-padded samples never raise dout_valid.
    assign emit     = sys_en_glb && filled && !flush_stop;

`ifdef R22SDF_BITREV_IDX_EN
    r22sdf_bitrev #(
        .width (IDX_W)
    ) u_bitrev (
        .din  (out_cnt),
        .dout (idx_next)
    );
`else
    assign idx_next = out_cnt;
`endif

    // Handshake and enable follow state and din_valid with no added latency.
    // A ready drop in RUN/FLUSH freezes the pipeline in the same cycle.
    // In IDLE only the sop sample advances the pipeline, as frame index 0.
    always_comb begin
        din_ready  = 1'b0;
        din_zero   = 1'b0;
        sys_en_glb = 1'b0;
        case (state)
            IDLE: begin
                din_ready  = 1'b1;
                sys_en_glb = din_valid && din_sop;
            end
            RUN: begin
                din_ready  = rdy_ok;
                sys_en_glb = din_valid && rdy_ok;
            end
            FLUSH: begin
                din_zero   = 1'b1;
                sys_en_glb = rdy_ok;
            end
            default: ;
        endcase
    end

    // Main sequencer: state, counters, flush latch and registered output tags.
    // The state-specific branches come after the output update so that a
    // clear on a state change takes priority over the counter advance.
    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            state       <= INIT;
            in_cnt      <= '0;
            out_cnt     <= '0;
            fill_cnt    <= '0;
            flush_cnt   <= '0;
            flush_latch <= 1'b0;
            flush_stop  <= 1'b0;
            dout_valid  <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            dout_idx    <= '0;
            err_sop     <= 1'b0;
        end else begin
            err_sop <= 1'b0;

            if (emit) begin
                dout_valid <= 1'b1;
                dout_sop   <= (out_cnt == '0);
                dout_eop   <= (out_cnt == LAST_IDX);
                dout_idx   <= idx_next;
                out_cnt    <= (out_cnt == LAST_IDX) ? '0 : out_cnt + IDX_W'(1);
                if (state == FLUSH && out_cnt == LAST_IDX) begin
                    flush_stop <= 1'b1;
                end
            end else begin
                dout_valid <= 1'b0;
                dout_sop   <= 1'b0;
                dout_eop   <= 1'b0;
                dout_idx   <= '0;
            end

            if (sys_en_glb && !filled) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end

            if (lose_rdy) begin
                state       <= INIT;
                in_cnt      <= '0;
                out_cnt     <= '0;
                fill_cnt    <= '0;
                flush_cnt   <= '0;
                flush_latch <= 1'b0;
                flush_stop  <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        if (rdy_ok) state <= IDLE;
                    end
                    IDLE: begin
                        if (din_valid && din_sop) begin
                            state  <= RUN;
                            in_cnt <= IDX_W'(1);
                        end
                    end
                    RUN: begin
                        if (flush_req) flush_latch <= 1'b1;
                        if (din_valid) begin
                            // A stray sop restarts the frame at this sample
                            // and overrides a pending end-of-frame flush.
                            if (din_sop && in_cnt != '0) begin
                                err_sop <= 1'b1;
                                in_cnt  <= IDX_W'(1);
                            end else if (in_cnt == LAST_IDX && (flush_latch || flush_req)) begin
                                state       <= FLUSH;
                                in_cnt      <= '0;
                                flush_cnt   <= '0;
                                flush_latch <= 1'b0;
                            end else begin
                                in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + IDX_W'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state      <= IDLE;
                            flush_cnt  <= '0;
                            fill_cnt   <= '0;
                            out_cnt    <= '0;
                            flush_stop <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

endmodule

// File: doc/r22sdf_ctrl.md
# r22sdf_ctrl

Frame sequencer for the radix-2² SDF FFT pipeline. Gates the global pipeline enable from the input stream, holds the pipeline until every twiddle stage reports its CORDIC table ready, counts pipeline fill, and flushes the last frame with zero samples. It also tags output samples with valid, start-of-frame, end-of-frame and bin index. It sits between the sample source and the chain of butterfly/twiddle stages.

## Interface
- fft_length, 16, transform size; a power of 4, ≥ 4
- num_stages, clog4(fft_length), number of butterfly stages (width of cordic_rdy)
- pipe_latency, fft_length-1, enabled cycles from input sample 0 to output sample 0 (includes stage FF options)
- sys_clk  in  1  clock
- sys_nrst  in  1  reset; synchronous, active-low
- din_valid  in  1  input sample present this cycle
- din_sop  in  1  with din_valid: sample is frame index 0
- flush_req  in  1  request drain after current frame
- cordic_rdy  in  num_stages  per-stage twiddle ROM/CORDIC ready
- din_ready  out  1  controller accepts din this cycle
- din_zero  out  1  upstream must drive zero samples (flush)
- sys_en_glb  out  1  pipeline advance enable
- dout_valid  out  1  pipeline output sample valid
- dout_sop  out  1  output bin sequence 0
- dout_eop  out  1  output bin sequence fft_length-1
- dout_idx  out  clog2(fft_length)  output bin index
- busy  out  1  state ≠ IDLE/INIT
- err_sop  out  1  one-cycle pulse: misplaced din_sop

## Operation
- States: INIT, IDLE, RUN, FLUSH.
- INIT: all outputs low. Go IDLE when &cordic_rdy is 1 for one sampled cycle.
- IDLE: din_ready=1. Go RUN on din_valid&din_sop; that sample is accepted as index 0. Non-sop samples are dropped silently.
- RUN: din_ready=1; sys_en_glb = din_valid. in_cnt (clog2(fft_length) bits) increments per accepted sample, wrapping at fft_length-1.
- din_sop with in_cnt≠0: pulse err_sop; in_cnt restarts at 0 with this sample; fill state kept.
- flush_req is latched (sticky) in RUN. When the sample with in_cnt=fft_length-1 is accepted and the latch is set, go FLUSH.
- FLUSH: din_ready=0, din_zero=1, sys_en_glb=1 every cycle for exactly pipe_latency cycles, then go IDLE with fill cleared.
- Fill: fill_cnt counts enabled cycles, saturating at pipe_latency; filled = (fill_cnt==pipe_latency).
- Output: each enabled cycle with filled=1 produces one output. out_cnt increments, wrapping at fft_length-1. dout_sop when out_cnt=0; dout_eop when out_cnt=fft_length-1.
- In FLUSH, outputs stop when out_cnt wraps after the last real frame. Zero-padded outputs never assert dout_valid.
- &cordic_rdy falls in RUN/FLUSH: go INIT; fill, in_cnt, out_cnt and the flush latch are cleared.

## Timing
- Reset (sys_nrst=0 at an edge): state INIT; every output 0; all counters and latches 0.
- sys_en_glb, din_ready, din_zero are combinational from state and din_valid. No added latency.
- dout_valid/sop/eop/idx are registered: asserted in the cycle after the enabling edge, aligned with stage output data.
- First dout_valid: the cycle after the (pipe_latency+1)-th enabled cycle after the frame's sop.
- Simultaneous flush_req with the last sample of a frame: it is latched and takes effect on that sample.
- err_sop and go-FLUSH on the same sample: err_sop wins; in_cnt=0 and stay RUN.

## Configuration
- R22SDF_BITREV_IDX_EN defined: dout_idx = bit-reverse(out_cnt), i.e. the true frequency bin of the digit-reversed R2² output order.
- Not defined: dout_idx = out_cnt (arrival order); the reorder is left to downstream.

## Structure
- Package r22sdf_pkg: state enum (INIT=0, IDLE=1, RUN=2, FLUSH=3), clog2/clog4 functions (shared with logfunc.vh users), index width constant.
- One sub-module: r22sdf_bitrev, parameterised-width combinational reverser, instanced only under R22SDF_BITREV_IDX_EN.

## Test plan
- Reset/INIT: cordic_rdy=0 for 20 cycles then all ones -> all outputs 0, then IDLE one cycle later with din_ready=1.
- Streaming, fft_length=16, pipe_latency=15: two contiguous frames -> first dout_valid one cycle after the 16th enabled cycle; dout_sop at frame start, dout_eop 15 valids later; 32 valids total.
- Gapped input: din_valid toggling every cycle -> sys_en_glb mirrors din_valid; output count and sop/eop positions unchanged.
- Flush: flush_req mid-frame 2 -> after sample 15, din_zero=1 for 15 cycles, exactly 16 more valids, then IDLE with busy=0.
- Misplaced sop: din_sop at in_cnt=5 -> err_sop one cycle; next eop input sample is 15 samples after the stray sop.
- Ready loss: cordic_rdy[1]=0 mid-RUN -> sys_en_glb=0 the same cycle, state INIT, fill cleared; on recovery a new sop is required.
- Macro on: out_cnt=1 gives dout_idx=8; macro off gives dout_idx=1.
